adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder between two requesters using valid/ready handshakes.
- Arbitration is round-robin. One operation is in flight at a time.
- Each result is registered and returned only to the requester that issued it.
- Sits between on-chip requesters and the add datapath; a later revision maps requesters onto ui_in/uio_in and the result onto uo_out.

Parameters:
- WIDTH, 8, operand and sum width.
- SATURATE, 0, when 1, sum clamps to all-ones on carry-out.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  2  bit i = requester i has an operation pending.
- req_ready  out  2  bit i = requester i's operation is accepted this cycle.
- req_a  in  2*WIDTH  operand A, packed {a1,a0}.
- req_b  in  2*WIDTH  operand B, packed {b1,b0}.
- rsp_valid  out  2  bit i = result for requester i is presented.
- rsp_ready  in  2  bit i = requester i takes the result.
- rsp_sum  out  WIDTH  result sum (shared bus).
- rsp_carry  out  1  unsaturated carry-out of A+B.
- busy  out  1  high while a result is held (RESP state).
- ops_done  out  8  count of completed response handshakes.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; every register is reset on the clk edge where rst=1.
- Reset values:
  - state=IDLE, prio=0.
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, busy=0, ops_done=0.
  - req_ready=0 while rst=1.
- State IDLE:
  - req_ready is combinational from req_valid and prio; at most one bit is high.
  - Only one requester valid: it is granted.
  - Both valid: requester prio is granted.
  - None valid: req_ready=0.
  - Accept: when req_valid[g] & req_ready[g], on that edge:
    - compute {c,s} = a_g + b_g at WIDTH+1 bits;
    - register rsp_carry=c;
    - register rsp_sum = (SATURATE && c) ? all-ones : s;
    - register owner=g;
    - go to RESP.
- State RESP:
  - req_ready=0. rsp_valid[owner]=1, other bit 0. busy=1.
  - rsp_sum and rsp_carry are held stable.
  - On rsp_ready[owner]:
    - go to IDLE;
    - prio = ~owner;
    - ops_done += 1, wrapping 255 -> 0.
  - rsp_ready of the non-owner is ignored.
- Latency and throughput:
  - Result visible one cycle after the accept edge.
  - Minimum 2 cycles per operation; there is no accept in the same cycle as a response handshake.
- Requester rules:
  - Requesters hold valid and operands stable until ready.
  - Deasserting valid before ready is legal and simply withdraws the request (no grant, prio unchanged).
- Wrap: operands all-ones + all-ones gives sum = all-ones minus 1 with carry=1 (unsaturated), or all-ones (saturated).
- Reset mid-operation: a pending result is discarded. rsp_valid drops on the next edge with no handshake and ops_done is not incremented. prio returns to 0.
- Width rule: ops_done is fixed at 8 bits regardless of WIDTH. The addition is unsigned.

Decomposition:
- Shared package adder_share_pkg:
  - state enum {ST_IDLE, ST_RESP};
  - localparam NREQ=2;
  - requester ID constants REQ0=0, REQ1=1.
- One sub-module, rr_arb2: a combinational 2-way round-robin grant from (valid[1:0], prio) to one-hot grant[1:0].
- Adder, state register, prio and counter stay in the top.

Test Plan:
- Reset, then req_valid=01, a0=0x12, b0=0x34, rsp_ready=01 -> req_ready=01 for one cycle; next cycle rsp_valid=01, rsp_sum=0x46, rsp_carry=0; then ops_done=1, busy=0.
- Both valid every cycle with a0=1,b0=1 and a1=2,b1=2, rsp_ready=11 -> grants alternate 0,1,0,1; sums alternate 0x02,0x04; ops_done=4 after 8 cycles.
- a0=0xFF, b0=0x01, SATURATE=0 -> sum=0x00, carry=1. Same operands with SATURATE=1 -> sum=0xFF, carry=1.
- Hold rsp_ready=00 for 5 cycles in RESP with req_valid=11 -> rsp_valid, rsp_sum and rsp_carry are stable, req_ready=00 throughout, ops_done unchanged.
- Assert rst one cycle while in RESP -> next cycle rsp_valid=00, busy=0, ops_done=0; with both requesters valid, requester 0 is granted first.
- Run 256 completed operations -> ops_done wraps to 0x00.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared definitions for the two-requester shared-adder arbiter.
//   state_t    : controller state encoding (idle / holding a result)
//   NREQ       : number of requesters sharing the adder
//   REQ0, REQ1 : requester IDs, also the bit index into req_*/rsp_* vectors
package adder_share_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam int NREQ = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter.
//   valid [1:0] : request lines
//   prio        : requester that wins when both request
//   grant [1:0] : one-hot grant, zero when nobody requests
module rr_arb2
  import adder_share_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            prio,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == REQ1) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one WIDTH-bit adder between two valid/ready requesters.
// Round-robin arbitration, one operation in flight; the registered result
// is presented only to the requester that issued it.
//
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operation pending
//   req_ready  : per-requester accept (combinational, one-hot or zero)
//   req_a/b    : packed operands {x1,x0}
//   rsp_valid  : per-requester result presented
//   rsp_ready  : per-requester result taken
//   rsp_sum    : registered sum (clamped to all-ones on carry if SATURATE)
//   rsp_carry  : registered unsaturated carry-out
//   busy       : a result is being held
//   ops_done   : completed response handshakes, 8-bit wrapping
//
// state   | meaning
// ST_IDLE | waiting for a request; arbiter drives req_ready
// ST_RESP | result held for owner until rsp_ready[owner]
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_carry,
  output logic                 busy,
  output logic [7:0]           ops_done
);

  state_t           state_q, state_d;
  logic             prio_q;
  logic             owner_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [7:0]       ops_q;

  logic [NREQ-1:0]  grant;
  logic             gnt_id;
  logic             accept;
  logic             done;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   full_sum;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio_q),
    .grant (grant)
  );

  assign gnt_id   = grant[REQ1] ? REQ1 : REQ0;
  assign a_sel    = (gnt_id == REQ1) ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign b_sel    = (gnt_id == REQ1) ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign full_sum = {1'b0, a_sel} + {1'b0, b_sel};

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Masked during reset so no requester sees a phantom accept.
        if (!rst) req_ready = grant;
        accept = |(req_valid & req_ready);
        if (accept) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= REQ0;
      owner_q <= REQ0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt_id;
        carry_q <= full_sum[WIDTH];
        sum_q   <= (SATURATE && full_sum[WIDTH]) ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
      end
      if (done) begin
        prio_q <= ~owner_q;
        ops_q  <= ops_q + 8'd1;
      end
    end
  end

  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign busy      = (state_q == ST_RESP);
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: an unsaturated and a saturated
// instance share every input and run in lockstep, each with its own
// expected-response queue and monitor.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_sum, ops_done;
  logic        rsp_carry, busy;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [7:0]  s_rsp_sum, s_ops_done;
  logic        s_rsp_carry, s_busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_ops  = 8'd0;

  typedef struct {
    logic       owner;
    logic [7:0] sum;
    logic       carry;
  } exp_t;

  exp_t q_n[$];
  exp_t q_s[$];
  exp_t en, es;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(8), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy), .ops_done(ops_done)
  );

  adder_share_arbiter #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(s_rsp_sum), .rsp_carry(s_rsp_carry), .busy(s_busy), .ops_done(s_ops_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_op(input logic owner, input logic [7:0] sum_n,
                           input logic [7:0] sum_s, input logic carry);
    q_n.push_back('{owner: owner, sum: sum_n, carry: carry});
    q_s.push_back('{owner: owner, sum: sum_s, carry: carry});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 8'd0;
  endtask

  // One operation from a single requester; expects to start in IDLE.
  task automatic single_op(input logic req, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] sum_n, input logic [7:0] sum_s,
                           input logic carry);
    if (req) begin
      req_a = {a, 8'h00}; req_b = {b, 8'h00}; req_valid = 2'b10;
    end else begin
      req_a = {8'h00, a}; req_b = {8'h00, b}; req_valid = 2'b01;
    end
    rsp_ready = 2'b11;
    expect_op(req, sum_n, sum_s, carry);
    @(negedge clk);
    chk("single_grant", req_ready, req ? 2'b10 : 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_busy_resp", busy, 1'b1);
    tick();
    exp_ops++;
    chk("single_ops_done", ops_done, exp_ops);
    chk("single_busy_idle", busy, 1'b0);
  endtask

  // Scoreboard monitors: pop on every response handshake.
  always @(negedge clk) begin
    if (!rst && |(rsp_valid & rsp_ready)) begin
      if (q_n.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, expected no response", rsp_valid);
      end else begin
        en = q_n.pop_front();
        chk("rsp_owner", rsp_valid, en.owner ? 2'b10 : 2'b01);
        chk("rsp_sum", rsp_sum, en.sum);
        chk("rsp_carry", rsp_carry, en.carry);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && |(s_rsp_valid & rsp_ready)) begin
      if (q_s.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sat_rsp_unexpected: got rsp_valid 0x%0h, expected no response", s_rsp_valid);
      end else begin
        es = q_s.pop_front();
        chk("sat_rsp_owner", s_rsp_valid, es.owner ? 2'b10 : 2'b01);
        chk("sat_rsp_sum", s_rsp_sum, es.sum);
        chk("sat_rsp_carry", s_rsp_carry, es.carry);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0; rsp_ready = 2'b00;
    @(negedge clk);
    chk("ready_in_reset", req_ready, 2'b00);
    tick();
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ops_done", ops_done, 8'd0);
    chk("rst_sum", rsp_sum, 8'd0);
    chk("rst_carry", rsp_carry, 1'b0);
    tick();

    // Basic single op from requester 0.
    single_op(1'b0, 8'h12, 8'h34, 8'h46, 8'h46, 1'b0);

    // Both always valid: grants alternate 0,1,0,1 from prio 0.
    do_reset();
    req_a = {8'h02, 8'h01}; req_b = {8'h02, 8'h01};
    req_valid = 2'b11; rsp_ready = 2'b11;
    expect_op(1'b0, 8'h02, 8'h02, 1'b0);
    expect_op(1'b1, 8'h04, 8'h04, 1'b0);
    expect_op(1'b0, 8'h02, 8'h02, 1'b0);
    expect_op(1'b1, 8'h04, 8'h04, 1'b0);
    repeat (8) tick();
    exp_ops = 8'd4;
    chk("alt_ops_done", ops_done, exp_ops);
    req_valid = 2'b00;

    // Carry-out and wrap, unsaturated vs saturated.
    single_op(1'b0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b1);
    single_op(1'b1, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 1'b1);

    // Stall in RESP for 5 cycles; last owner was 1 so requester 0 wins.
    req_a = {8'h05, 8'h10}; req_b = {8'h06, 8'h20};
    req_valid = 2'b11; rsp_ready = 2'b00;
    expect_op(1'b0, 8'h30, 8'h30, 1'b0);
    expect_op(1'b1, 8'h0B, 8'h0B, 1'b0);
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 2'b01);
      chk("stall_sum", rsp_sum, 8'h30);
      chk("stall_carry", rsp_carry, 1'b0);
      chk("stall_req_ready", req_ready, 2'b00);
      chk("stall_ops_done", ops_done, exp_ops);
      tick();
    end
    rsp_ready = 2'b11;
    repeat (3) tick();
    exp_ops = exp_ops + 8'd2;
    req_valid = 2'b00;
    chk("post_stall_ops_done", ops_done, exp_ops);

    // Reset while a result is held: result discarded, prio back to 0.
    req_a = {8'h00, 8'h0A}; req_b = {8'h00, 8'h0B};
    req_valid = 2'b01; rsp_ready = 2'b00;
    tick();
    @(negedge clk);
    chk("pre_rst_rsp_valid", rsp_valid, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 8'd0;
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ops_done", ops_done, 8'd0);
    req_a = {8'h20, 8'h0A}; req_b = {8'h22, 8'h0B};
    req_valid = 2'b11; rsp_ready = 2'b11;
    expect_op(1'b0, 8'h15, 8'h15, 1'b0);
    expect_op(1'b1, 8'h42, 8'h42, 1'b0);
    @(negedge clk);
    chk("midrst_first_grant", req_ready, 2'b01);
    repeat (4) tick();
    req_valid = 2'b00;
    chk("midrst_ops_after", ops_done, 8'd2);

    // 256 completed operations: ops_done wraps to 0.
    do_reset();
    req_a = {8'h80, 8'h03}; req_b = {8'h80, 8'h04};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) expect_op(1'b0, 8'h07, 8'h07, 1'b0);
      else            expect_op(1'b1, 8'h00, 8'hFF, 1'b1);
    end
    repeat (510) tick();
    chk("wrap_ops_255", ops_done, 8'hFF);
    repeat (2) tick();
    req_valid = 2'b00;
    chk("wrap_ops_0", ops_done, 8'h00);
    chk("wrap_sat_ops_0", s_ops_done, 8'h00);

    repeat (3) tick();
    chk("queue_n_drained", q_n.size(), 0);
    chk("queue_s_drained", q_s.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
